// File: rtl/seq_div_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div_if
//  Description : Operand/result bundle for the sequential divider.
//                The start/fin handshake matches the shift-add multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_div_if #(
    parameter int NW = 16,
    parameter int DW = 8
);
    logic          start;
    logic [NW-1:0] N;
    logic [DW-1:0] D;
    logic [NW-1:0] Q;
    logic [DW-1:0] R;
    logic          fin;
    logic          busy;
    logic          dz;

    modport master (output start, N, D, input  Q, R, fin, busy, dz);
    modport slave  (input  start, N, D, output Q, R, fin, busy, dz);
endinterface
`default_nettype wire

// File: rtl/seq_div.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div
//  Description : Restoring divider, one quotient bit per clock, MSB first.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_div #(
    parameter int NW = 16,
    parameter int DW = 8
) (
    input  wire logic  ck,
    input  wire logic  rst,
    seq_div_if.slave   bus
);
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DZ   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    r_state;
    logic [NW-1:0] r_dvd;
    logic [DW-1:0] r_dvs;
    logic [DW:0]   r_p;
    logic [CW-1:0] r_cnt;
    logic [NW-1:0] r_q;
    logic [DW-1:0] r_r;
    logic          r_fin;
    logic          r_busy;
    logic          r_dz;

    logic [DW:0]   w_shift;
    logic          w_ge;
    logic [DW:0]   w_pnext;
    logic [NW-1:0] w_qnext;

    // One extra bit on the partial remainder absorbs the shifted-in dividend bit.
    assign w_shift = {r_p[DW-1:0], r_dvd[NW-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_pnext = w_ge ? (w_shift - {1'b0, r_dvs}) : w_shift;
    assign w_qnext = {r_dvd[NW-2:0], w_ge};

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_fin   <= 1'b0;
            r_busy  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_fin <= 1'b0;
            if (bus.start) begin
                if (bus.D != '0) begin
                    r_dvd   <= bus.N;
                    r_dvs   <= bus.D;
                    r_p     <= '0;
                    r_cnt   <= CW'(NW - 1);
                    r_busy  <= 1'b1;
                    r_dz    <= 1'b0;
                    r_state <= S_RUN;
                end else begin
                    // Results are known immediately; S_DZ only delays fin one edge.
                    r_q     <= '1;
                    r_r     <= bus.N[DW-1:0];
                    r_dz    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DZ;
                end
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_p   <= w_pnext;
                        r_dvd <= w_qnext;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == '0) begin
                            r_q     <= w_qnext;
                            r_r     <= w_pnext[DW-1:0];
                            r_fin   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_dz    <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end
                    S_DZ: begin
                        r_fin   <= 1'b1;
                        r_state <= S_DONE;
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.Q    = r_q;
    assign bus.R    = r_r;
    assign bus.fin  = r_fin;
    assign bus.busy = r_busy;
    assign bus.dz   = r_dz;
endmodule
`default_nettype wire

// File: tb/tb_seq_div.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_div
//  Description : Self-checking bench for seq_div against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_div;
    logic ck  = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    seq_div_if #(.NW(16), .DW(8)) bus ();
    seq_div #(.NW(16), .DW(8)) dut (.ck(ck), .rst(rst), .bus(bus));

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] n, input logic [7:0] d,
                                  output logic [15:0] q, output logic [7:0] r);
        if (d == 8'd0) begin
            q = 16'hFFFF;
            r = n[7:0];
        end else begin
            q = n / {8'd0, d};
            r = 8'(n % {8'd0, d});
        end
    endfunction

    // Drives start for exactly one rising edge, then scrambles the operands.
    task automatic begin_op(input logic [15:0] n, input logic [7:0] d);
        bus.start = 1'b1;
        bus.N     = n;
        bus.D     = d;
        @(negedge ck);
        bus.start = 1'b0;
        bus.N     = 16'($urandom);
        bus.D     = 8'($urandom);
        chk("fin_after_start", 32'(bus.fin), 32'(0));
        chk("busy_after_start", 32'(bus.busy), 32'(d != 8'd0));
    endtask

    task automatic issue(input logic [15:0] n, input logic [7:0] d);
        @(negedge ck);
        begin_op(n, d);
    endtask

    task automatic wait_fin(input logic [15:0] n, input logic [7:0] d, input bit check_drop);
        int          lat;
        int          exp_lat;
        logic [15:0] eq;
        logic [7:0]  er;
        lat     = -1;
        exp_lat = (d == 8'd0) ? 1 : 16;
        model(n, d, eq, er);
        for (int k = 1; k <= 40; k++) begin
            @(negedge ck);
            if (bus.fin) begin
                lat = k;
                break;
            end
            if (k < exp_lat) chk("busy_running", 32'(bus.busy), 32'(d != 8'd0));
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        if (lat > 0) begin
            chk("Q", 32'(bus.Q), 32'(eq));
            chk("R", 32'(bus.R), 32'(er));
            chk("dz", 32'(bus.dz), 32'(d == 8'd0));
            chk("busy_with_fin", 32'(bus.busy), 32'(0));
            if (check_drop) begin
                @(negedge ck);
                chk("fin_one_cycle", 32'(bus.fin), 32'(0));
            end
        end
    endtask

    initial begin
        logic [15:0] rn;
        logic [7:0]  rd;
        bit          saw_fin;
        bus.start = 1'b0;
        bus.N     = '0;
        bus.D     = '0;

        #12;
        chk("rst_Q", 32'(bus.Q), 32'(0));
        chk("rst_R", 32'(bus.R), 32'(0));
        chk("rst_flags", 32'({bus.fin, bus.busy, bus.dz}), 32'(0));
        @(negedge ck);
        rst = 1'b0;

        issue(16'd1000, 8'd7);
        wait_fin(16'd1000, 8'd7, 1'b1);
        repeat (10) @(negedge ck);
        chk("hold_Q", 32'(bus.Q), 32'(142));
        chk("hold_R", 32'(bus.R), 32'(6));

        issue(16'd65535, 8'd1);   wait_fin(16'd65535, 8'd1, 1'b1);
        issue(16'd65535, 8'd255); wait_fin(16'd65535, 8'd255, 1'b1);
        issue(16'd5, 8'd9);       wait_fin(16'd5, 8'd9, 1'b1);
        issue(16'd0, 8'd3);       wait_fin(16'd0, 8'd3, 1'b1);

        issue(16'd1234, 8'd0);    wait_fin(16'd1234, 8'd0, 1'b1);
        issue(16'd100, 8'd10);    wait_fin(16'd100, 8'd10, 1'b1);

        // Restart mid-run: the first operation must never signal fin.
        issue(16'd1000, 8'd7);
        repeat (4) begin
            @(negedge ck);
            chk("no_fin_before_restart", 32'(bus.fin), 32'(0));
        end
        begin_op(16'd100, 8'd10);
        wait_fin(16'd100, 8'd10, 1'b1);

        // Asynchronous reset mid-operation.
        issue(16'd200, 8'd3);
        repeat (7) @(negedge ck);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_Q", 32'(bus.Q), 32'(0));
        chk("async_rst_R", 32'(bus.R), 32'(0));
        chk("async_rst_flags", 32'({bus.fin, bus.busy, bus.dz}), 32'(0));
        @(negedge ck);
        rst = 1'b0;
        saw_fin = 1'b0;
        repeat (40) begin
            @(negedge ck);
            if (bus.fin) saw_fin = 1'b1;
        end
        chk("no_fin_after_abort", 32'(saw_fin), 32'(0));
        issue(16'd200, 8'd3);
        wait_fin(16'd200, 8'd3, 1'b1);

        // New start during the DONE cycle.
        issue(16'd50, 8'd7);
        wait_fin(16'd50, 8'd7, 1'b0);
        begin_op(16'd81, 8'd9);
        wait_fin(16'd81, 8'd9, 1'b1);

        for (int i = 0; i < 25; i++) begin
            rn = 16'($urandom);
            rd = (i % 6 == 5) ? 8'd0 : 8'($urandom_range(1, 255));
            issue(rn, rd);
            wait_fin(rn, rd, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seq_div.md
Name: seq_div

Overview:
- Sequential restoring divider: unsigned NW-bit dividend by DW-bit divisor, producing quotient and remainder.
- Resolves one quotient bit per clock, MSB first.
- Inverse companion of the team's shift-add multiplier; uses the same start/fin handshake so the two blocks sit side by side in the arithmetic datapath.

Parameters:
NW, 16, dividend and quotient width
DW, 8, divisor and remainder width

Ports:
ck  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  sampled at posedge; loads N, D and begins a division
N  input  NW  dividend, sampled only when start=1
D  input  DW  divisor, sampled only when start=1
Q  output  NW  quotient, registered
R  output  DW  remainder, registered
fin  output  1  one-cycle completion pulse, registered
busy  output  1  high while an iteration is in progress, registered
dz  output  1  divide-by-zero flag for the last completed operation, registered

Behaviour:
- Reset (rst=1, asynchronous):
  - Q=0, R=0, fin=0, busy=0, dz=0; internal state goes IDLE.
  - Reset mid-operation aborts it; no fin is produced afterwards.
- States:
  - IDLE: waiting.
  - RUN: NW iterations.
  - DONE: single cycle, drives fin.
- Start, D != 0 (sampled at edge t0):
  - Latch N into the dividend/quotient shift register and D into the divisor register.
  - Clear the partial remainder (DW+1 bits); iteration counter = NW-1; busy=1; dz=0; go RUN.
- Start, D == 0:
  - No iterations. Next state DONE with Q={NW{1}}, R=N[DW-1:0], dz=1, busy=0.
  - fin is visible after edge t0+1.
- RUN iteration (each edge):
  - Partial remainder p = {p[DW-1:0], dividend MSB}; dividend shifts left one bit.
  - If p >= {1'b0, D}: p = p - D and the new quotient LSB = 1; else p is kept and the LSB = 0.
  - The counter decrements.
- Last iteration (counter == 0):
  - Write the final quotient to Q and p[DW-1:0] to R; fin=1, busy=0, dz=0; go DONE.
  - Total latency: fin is visible after edge t0+NW, i.e. 16 cycles for the defaults.
- DONE: fin returns to 0 on the next edge; go IDLE.
- Output hold: Q, R and dz hold their values until the next operation completes or reset. They are not cleared after fin, unlike the multiplier's O.
- start priority: start=1 has priority in every state.
  - Start in RUN restarts with the new operands; the old operation is discarded and produces no fin.
  - Start in the DONE cycle clears fin on that edge and begins the new operation.
- busy and fin are never both 1.
- Operands may change freely when start=0.
- Widths: the compare/subtract is done in DW+1 bits so the shifted-in bit cannot overflow. The remainder is always < D when dz=0.

Test Plan:
- Reset, then N=1000, D=7, start pulsed 1 cycle -> busy for 16 cycles; fin high exactly 1 cycle at t0+16 with Q=142, R=6, dz=0. Q and R still 142/6 ten cycles later.
- Boundary values, each run back-to-back, each fin 16 cycles after its start:
  - 65535/1 -> Q=65535, R=0.
  - 65535/255 -> Q=257, R=0.
  - 5/9 -> Q=0, R=5.
  - 0/3 -> Q=0, R=0.
- N=1234, D=0 -> fin one cycle after start; Q=0xFFFF, R=0xD2, dz=1, busy never asserted. Then 100/10 -> Q=10, R=0, dz=0.
- Start 1000/7; 5 cycles later start 100/10 -> no fin for the first operation; single fin 16 cycles after the second start with Q=10, R=0.
- Start 200/3; assert rst asynchronously (mid-cycle) 8 cycles in -> Q, R, fin, busy and dz go 0 immediately; no fin for 40 cycles. A fresh start 200/3 after release -> Q=66, R=2.
- Start asserted during the DONE cycle of 50/7 -> fin lasts 1 cycle; new operation 81/9 completes 16 cycles later with Q=9, R=0.
